fb_line_reader: RTL

FB_LINE_READER -- requirements
Module: fb_line_reader

---
 rtl/fb_line_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fb_line_reader.sv
// rtl/fb_line_reader.sv - fetches one framebuffer line per line_sys into the linebuffer stream
// Optional build macro: FB_LINE_READER_SKIP_EN (skip refetching the row that was fetched last).
module fb_line_reader #(
  parameter int DATAW  = 4,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180,
  parameter int SCALEW = 6,
  parameter int LAT    = 1
) (
  input  logic                               clk_sys,
  input  logic                               rst_sys_n,
  input  logic                               frame_sys,
  input  logic                               line_sys,
  input  logic [SCALEW-1:0]                  scale,
  output logic                               fb_rd,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    fb_addr,
  input  logic [DATAW-1:0]                   fb_data,
  output logic                               lb_en,
  output logic [DATAW-1:0]                   lb_data,
  output logic                               lb_valid,
  output logic                               busy
);

  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, READ, DRAIN} state_t;

  state_t            state;
  logic [RW-1:0]     row;
  logic [SCALEW-1:0] cnt_v;
  logic [AW-1:0]     row_base;
  logic [AW-1:0]     fetch_base;
  logic [CW-1:0]     col;
  logic [2:0]        dcnt;
  // vld tracks issued reads travelling through the memory latency; en_p
  // carries the start-of-line marker so lb_en lands one cycle before word 0.
  logic [LAT-1:0]    vld;
  logic [LAT-1:0]    en_p;

  logic [RW-1:0]     row_n;
  logic [SCALEW-1:0] cntv_n;
  logic [AW-1:0]     base_n;
  logic [SCALEW-1:0] scale_m1;
  logic              skip_hit;

`ifdef FB_LINE_READER_SKIP_EN
  logic [RW-1:0]     tgt_row;
  logic [RW-1:0]     last_row;
  logic              last_vld;
`endif

  // Counter values as seen by this line_sys: frame_sys clears them first.
  always_comb begin
    row_n    = frame_sys ? '0 : row;
    cntv_n   = frame_sys ? '0 : cnt_v;
    base_n   = frame_sys ? '0 : row_base;
    scale_m1 = (scale == '0) ? '0 : scale - SCALEW'(1);
    skip_hit = 1'b0;
`ifdef FB_LINE_READER_SKIP_EN
    skip_hit = last_vld && !frame_sys && (row_n == last_row);
`endif
  end

  assign busy     = (state != IDLE);
  assign lb_valid = vld[LAT-1];
  assign lb_en    = en_p[LAT-1];
  assign lb_data  = lb_valid ? fb_data : '0;

  // Row/vertical bookkeeping, fetch FSM and read-latency pipeline.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state      <= IDLE;
      row        <= '0;
      cnt_v      <= '0;
      row_base   <= '0;
      fetch_base <= '0;
      col        <= '0;
      dcnt       <= '0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      vld        <= '0;
      en_p       <= '0;
`ifdef FB_LINE_READER_SKIP_EN
      tgt_row    <= '0;
      last_row   <= '0;
      last_vld   <= 1'b0;
`endif
    end else begin
      vld     <= vld << 1;
      vld[0]  <= fb_rd;
      en_p    <= en_p << 1;
      en_p[0] <= 1'b0;
      if (line_sys) begin
        fetch_base <= base_n;
`ifdef FB_LINE_READER_SKIP_EN
        tgt_row    <= row_n;
        if (frame_sys) last_vld <= 1'b0;
`endif
        if (cntv_n >= scale_m1) begin
          cnt_v <= '0;
          if (row_n != RW'(HEIGHT-1)) begin
            row      <= row_n + RW'(1);
            row_base <= base_n + AW'(WIDTH);
          end else begin
            row      <= row_n;
            row_base <= base_n;
          end
        end else begin
          cnt_v    <= cntv_n + SCALEW'(1);
          row      <= row_n;
          row_base <= base_n;
        end
        vld   <= '0;
        en_p  <= '0;
        fb_rd <= 1'b0;
        col   <= '0;
        state <= skip_hit ? IDLE : PREP;
      end else if (frame_sys) begin
        row      <= '0;
        cnt_v    <= '0;
        row_base <= '0;
        vld      <= '0;
        en_p     <= '0;
        fb_rd    <= 1'b0;
        state    <= IDLE;
`ifdef FB_LINE_READER_SKIP_EN
        last_vld <= 1'b0;
`endif
      end else begin
        case (state)
          PREP: begin
            state   <= READ;
            fb_rd   <= 1'b1;
            fb_addr <= fetch_base;
            col     <= '0;
            en_p[0] <= 1'b1;
          end
          READ: begin
            if (col == CW'(WIDTH-1)) begin
              fb_rd <= 1'b0;
              dcnt  <= '0;
              state <= DRAIN;
            end else begin
              col     <= col + CW'(1);
              fb_addr <= fb_addr + AW'(1);
            end
          end
          DRAIN: begin
            if (dcnt == 3'(LAT-1)) begin
              state <= IDLE;
`ifdef FB_LINE_READER_SKIP_EN
              last_row <= tgt_row;
              last_vld <= 1'b1;
`endif
            end else begin
              dcnt <= dcnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
